uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tick_gen.sv | 38 +++
 rtl/uart_rx_cfg.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: definitions shared by the UART receive path.
//   state_t        receiver FSM state encoding
//   PAR_*          encodings of the 2-bit parity-mode input
//   TICKS_PER_BIT  oversample ticks per serial bit
//   parity_enabled helper: does this parity mode carry a parity bit?
//   majority3      helper: 2-of-3 vote over the mid-bit samples
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam int TICKS_PER_BIT = 16;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_tick_gen: oversample tick generator.
// Emits a one-clock pulse on 'tick' every 'div' clocks (div==0 behaves as 1).
// While 'clear' is high the divider is held at zero and no tick is produced,
// so the first tick after clear drops arrives exactly 'div' clocks later.
// Ports:
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   clear             hold the divider in its start position
//   div               clocks per tick
//   tick              one-clock tick pulse
// ---------------------------------------------------------------------------
module uart_tick_gen #(
    parameter int DIV_WIDTH = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_eff;

    assign div_eff = (div == '0) ? DIV_WIDTH'(1) : div;
    assign tick    = !clear && (cnt == div_eff - DIV_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg: UART receiver with runtime-configurable rate, parity and stop
// bits. 16x oversampling, 2-of-3 majority vote at ticks 6/7/8 of each bit.
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_rx               serial line (idle high), asynchronous
//   i_div              clocks per oversample tick (0 treated as 1)
//   i_parity_mode      00 none, 01 even, 10 odd, 11 none
//   i_stop2            1: two stop bits, 0: one stop bit
//   o_valid/i_ready    word handshake: the word is transferred on every clock
//                      edge where o_valid && i_ready; o_data and the flags stay
//                      stable while o_valid is high and i_ready is low
//   o_data             received word, LSB first on the line
//   o_parity_err, o_frame_err, o_break   status, qualified by o_valid
//   o_overrun          sticky: a completed frame was dropped; cleared by handshake
//   o_busy             receiver FSM is outside IDLE
//   dbg_state          current FSM state
// ---------------------------------------------------------------------------
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_rx,
    input  logic [DIV_WIDTH-1:0]  i_div,
    input  logic [1:0]            i_parity_mode,
    input  logic                  i_stop2,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    output logic                  o_busy,
    output state_t                dbg_state
);

    localparam int              BCW      = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

    state_t state, state_next;

    logic                  rx_meta, rxs;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [1:0]            par_q;
    logic                  stop2_q;
    logic                  tick;
    logic [3:0]            tick_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic                  stop_idx;
    logic                  s6_q, s7_q;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  par_bit_q, perr_q, ferr_q, stop0_zero_q;

    logic at_mid, at_end, maj, par_en, final_stop;
    logic start_det, frame_done;
    logic first_stop_zero, brk_now, ferr_now, perr_now, handshake;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    // The divider runs only while a frame is being received, so tick 0 of the
    // start bit falls i_div clocks after the falling edge was seen.
    uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     ((state == ST_IDLE) || (state == ST_BRK_WAIT)),
        .div       (div_q),
        .tick      (tick)
    );

    assign at_mid     = tick && (tick_cnt == 4'd8);
    assign at_end     = tick && (tick_cnt == 4'd15);
    // Third sample is the live value at tick 8; ticks 6 and 7 are registered.
    assign maj        = majority3(s6_q, s7_q, rxs);
    assign par_en     = parity_enabled(par_q);
    assign final_stop = (stop_idx == stop2_q);

    // Completion status, evaluated in the clock the final stop bit is voted.
    assign first_stop_zero = (stop_idx == 1'b0) ? !maj : stop0_zero_q;
    assign brk_now         = (data_sr == '0) && !par_bit_q && first_stop_zero;
    assign ferr_now        = ferr_q | !maj;
    assign perr_now        = perr_q & !brk_now;
    assign handshake       = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    start_det  = 1'b1;
                end
            end
            ST_START: begin
                if (at_mid && maj) begin
                    state_next = ST_IDLE;
                end else if (at_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end && (bit_cnt == LAST_BIT)) begin
                    state_next = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_mid && final_stop) begin
                    frame_done = 1'b1;
                    state_next = brk_now ? ST_BRK_WAIT : ST_IDLE;
                end
            end
            ST_BRK_WAIT: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame datapath: counters, samples and per-frame configuration.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_q        <= '0;
            par_q        <= PAR_NONE;
            stop2_q      <= 1'b0;
            tick_cnt     <= 4'd0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            s6_q         <= 1'b1;
            s7_q         <= 1'b1;
            data_sr      <= '0;
            par_bit_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop0_zero_q <= 1'b0;
        end else if (start_det) begin
            div_q        <= i_div;
            par_q        <= i_parity_mode;
            stop2_q      <= i_stop2;
            tick_cnt     <= 4'd0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            s6_q         <= 1'b1;
            s7_q         <= 1'b1;
            data_sr      <= '0;
            par_bit_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop0_zero_q <= 1'b0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd6) s6_q <= rxs;
            if (tick_cnt == 4'd7) s7_q <= rxs;
            if (at_mid) begin
                case (state)
                    ST_DATA: data_sr <= {maj, data_sr[DATA_WIDTH-1:1]};
                    ST_PARITY: begin
                        par_bit_q <= maj;
                        perr_q    <= maj ^ (^data_sr) ^ (par_q == PAR_ODD);
                    end
                    ST_STOP: begin
                        if (stop_idx == 1'b0) begin
                            stop0_zero_q <= !maj;
                            ferr_q       <= !maj;
                        end
                    end
                    default: ;
                endcase
            end
            if (at_end) begin
                if ((state == ST_DATA) && (bit_cnt != LAST_BIT)) begin
                    bit_cnt <= bit_cnt + BCW'(1);
                end
                if (state == ST_STOP) begin
                    stop_idx <= 1'b1;
                end
            end
        end
    end

    // Output holding register and overrun tracking.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (frame_done && (!o_valid || handshake)) begin
                o_valid      <= 1'b1;
                o_data       <= brk_now ? '0 : data_sr;
                o_parity_err <= perr_now;
                o_frame_err  <= ferr_now;
                o_break      <= brk_now;
            end else if (handshake) begin
                o_valid <= 1'b0;
            end
            if (frame_done && o_valid && !i_ready) begin
                o_overrun <= 1'b1;
            end else if (handshake) begin
                o_overrun <= 1'b0;
            end
        end
    end

    assign o_busy    = (state != ST_IDLE);
    assign dbg_state = state;

endmodule
